// File: rtl/fifo_v4_pkg.sv
// fifo_v4 shared helpers.
// Index-width math for arbitrary (non-power-of-two) depths.
package fifo_v4_pkg;

    // Bits needed to index n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v4.sv
// fifo_v4: synchronous FIFO with runtime watermarks, fill count,
// sticky overflow/underflow flags and optional fall-through.
module fifo_v4
    import fifo_v4_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [CNT_WIDTH-1:0]  alm_full_th_i,
    input  logic [CNT_WIDTH-1:0]  alm_empty_th_i,
    input  logic                  clr_err_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  alm_full_o,
    output logic                  alm_empty_o,
    output logic [CNT_WIDTH-1:0]  usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  is_empty;
    logic                  bypass;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  ovf_set;
    logic                  udf_set;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    // Accept decisions; the bypass case never touches storage or count.
    always_comb begin
        is_empty = (count == '0);
        bypass   = FALL_THROUGH && is_empty && push_i && pop_i;
        pop_ok   = pop_i && !is_empty;
        push_ok  = push_i && !bypass
                   && ((count < DEPTH_C) || pop_ok);
        ovf_set  = !flush_i && push_i && !push_ok && !bypass;
        udf_set  = !flush_i && pop_i && is_empty && !bypass;
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (!flush_i && push_ok) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointer and fill-count update with explicit wrap at DEPTH-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clr_err_i) begin
                overflow_o <= 1'b0;
            end
            if (udf_set) begin
                underflow_o <= 1'b1;
            end else if (clr_err_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

    // Status and head data, combinational from the registered count.
    always_comb begin
        data_o      = mem[rd_ptr];
        if (FALL_THROUGH && is_empty) begin
            data_o = data_i;
        end
        empty_o     = is_empty && !(FALL_THROUGH && push_i);
        full_o      = (count == DEPTH_C);
        alm_full_o  = (count >= alm_full_th_i);
        alm_empty_o = (count <= alm_empty_th_i);
        usage_o     = count;
    end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
    if (DEPTH < 1) begin : g_depth_chk
        $error("fifo_v4: DEPTH must be at least 1");
    end
    if (DATA_WIDTH < 1) begin : g_width_chk
        $error("fifo_v4: DATA_WIDTH must be at least 1");
    end

    afull_th_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        alm_full_th_i <= DEPTH_C
    ) else $warning("fifo_v4: alm_full_th_i exceeds DEPTH");

    aempty_th_range: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        alm_empty_th_i <= DEPTH_C
    ) else $warning("fifo_v4: alm_empty_th_i exceeds DEPTH");
`endif
`endif

endmodule
